// File: rtl/fp_accum_seq_if.sv
// Port bundle for fp_accum_seq: sample stream in, running-sum result out, initiator side of the sequential FP adder.
// master = accumulator side, slave = producer/consumer/adder side.
interface fp_accum_seq_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             sum_valid;
    logic             sum_ready;
    logic [31:0]      sum_data;
    logic [3:0]       sum_flags;
    logic [CNT_W-1:0] sum_count;
    logic             busy;
    logic             add_start;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_result;
    logic [3:0]       add_done;

    modport master (
        input  in_valid, in_data, in_last, sum_ready, add_result, add_done,
        output in_ready, sum_valid, sum_data, sum_flags, sum_count, busy, add_start, add_a, add_b
    );

    modport slave (
        output in_valid, in_data, in_last, sum_ready, add_result, add_done,
        input  in_ready, sum_valid, sum_data, sum_flags, sum_count, busy, add_start, add_a, add_b
    );
endinterface

// File: rtl/fp_accum_seq.sv
// float32 stream accumulator driving a sequential FP adder; adder latency + 3 cycles per sample, sum held until sum_ready.
// No sample is taken while an add or a result is pending. Option FP_ACCUM_SKIP_ZERO_EN: zero/denormal samples bypass the adder.
module fp_accum_seq #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_accum_seq_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_IN = 3'd1;
    localparam logic [2:0] ADD     = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] OUT     = 3'd4;

    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [31:0]      acc;
    logic [31:0]      opA;
    logic [31:0]      opB;
    logic [CNT_W-1:0] count;
    logic [3:0]       flags;
    logic             lastR;
    logic             sumValid;
    logic [1:0]       drainCnt;
    logic [TW-1:0]    timer;
    logic             skipZero;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign bus.in_ready  = rst_n && ((state == IDLE) || (state == WAIT_IN));
    assign bus.busy      = (state != IDLE);
    assign bus.add_start = (state == ADD) || (state == DRAIN);
    assign bus.sum_valid = sumValid;
    assign bus.sum_data  = acc;
    assign bus.sum_flags = flags;
    assign bus.sum_count = count;
    assign bus.add_a     = opA;
    assign bus.add_b     = opB;

`ifdef FP_ACCUM_SKIP_ZERO_EN
    assign skipZero = (bus.in_data[30:23] == 8'd0);
`else
    assign skipZero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            opA      <= '0;
            opB      <= '0;
            count    <= '0;
            flags    <= '0;
            lastR    <= 1'b0;
            sumValid <= 1'b0;
            drainCnt <= '0;
            timer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // First sample of a sum loads the accumulator directly.
                    if (bus.in_valid) begin
                        acc   <= bus.in_data;
                        count <= CNT_W'(1);
                        flags <= '0;
                        if (bus.in_last) begin
                            state    <= OUT;
                            sumValid <= 1'b1;
                        end else begin
                            state <= WAIT_IN;
                        end
                    end
                end
                WAIT_IN: begin
                    if (bus.in_valid) begin
                        count <= satInc(count);
                        if (skipZero) begin
                            if (bus.in_last) begin
                                state    <= OUT;
                                sumValid <= 1'b1;
                            end
                        end else begin
                            opA   <= acc;
                            opB   <= bus.in_data;
                            lastR <= bus.in_last;
                            timer <= '0;
                            state <= ADD;
                        end
                    end
                end
                ADD: begin
                    if (bus.add_done[0]) begin
                        acc        <= bus.add_result;
                        flags[2:0] <= flags[2:0] | bus.add_done[3:1];
                        drainCnt   <= 2'd2;
                        state      <= DRAIN;
                    end else if (timer == TLAST) begin
                        // Abandon the op; acc keeps the pre-add value.
                        flags[3] <= 1'b1;
                        state    <= OUT;
                        sumValid <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DRAIN: begin
                    // Hold start so the adder walks back to its idle step.
                    if (drainCnt == 2'd1) begin
                        state    <= lastR ? OUT : WAIT_IN;
                        sumValid <= lastR;
                    end else begin
                        drainCnt <= drainCnt - 1'b1;
                    end
                end
                OUT: begin
                    if (bus.sum_ready) begin
                        state    <= IDLE;
                        sumValid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq: expected sums queued at issue, popped by a monitor on each sum handshake.
module tb_fp_accum_seq;
    localparam int LAT = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  f;
        logic [15:0] c;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_accum_seq_if #(.CNT_W(16)) bus ();
    fp_accum_seq #(.TIMEOUT(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   total   = 0;
    int   bad     = 0;
    exp_t expQ[$];
    logic noDone  = 1'b0;
    logic skipRun = 1'b0;
    int   expRun  = LAT + 2;
    int   run     = 0;
    int   opCount = 0;
    int   aCnt    = 0;
    logic aHold   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] d, input logic [3:0] f, input logic [15:0] c);
        exp_t e;
        e.d = d;
        e.f = f;
        e.c = c;
        expQ.push_back(e);
    endtask

    function automatic logic [31:0] addLut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h3F000000}: return 32'h3FC00000;
            {32'h3FC00000, 32'h3FC00000}: return 32'h40400000;
            {32'h3F800000, 32'hBF800000}: return 32'h00000000;
            {32'h40000000, 32'h00000000}: return 32'h40000000;
            {32'h40000000, 32'h3F800000}: return 32'h40400000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Sequential adder model: result LAT cycles after start, then waits for start to drop.
    always @(negedge clk) begin
        bus.add_done = 4'd0;
        if (!bus.add_start) begin
            aCnt  = 0;
            aHold = 1'b0;
        end else if (!aHold && !noDone) begin
            aCnt++;
            if (aCnt == LAT) begin
                bus.add_result = addLut(bus.add_a, bus.add_b);
                bus.add_done   = (bus.add_result == 32'd0) ? 4'b0011 : 4'b0001;
                aHold          = 1'b1;
            end
        end
    end

    // Monitor: add_start run lengths, in_ready gating, scoreboard pops.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.add_start) begin
                run++;
                check("in_ready_low_during_add", bus.in_ready, 0);
            end else if (run > 0) begin
                if (!skipRun) check("add_start_run_len", run, expRun);
                opCount++;
                run = 0;
            end
            if (bus.sum_valid) check("in_ready_low_during_out", bus.in_ready, 0);
            if (bus.sum_valid && bus.sum_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sum_unexpected: got %h with empty queue", bus.sum_data);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("sum_data", bus.sum_data, e.d);
                    check("sum_flags", {28'd0, bus.sum_flags}, {28'd0, e.f});
                    check("sum_count", {16'd0, bus.sum_count}, {16'd0, e.c});
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic last);
        logic got;
        got          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready never seen for %h", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus.busy) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d busy=%b", expQ.size(), bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ops0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.in_last   = 1'b0;
        bus.sum_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_sum_valid", bus.sum_valid, 0);
        check("rst_sum_data", bus.sum_data, 0);
        check("rst_sum_flags", bus.sum_flags, 0);
        check("rst_sum_count", bus.sum_count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_add_start", bus.add_start, 0);
        check("rst_add_a", bus.add_a, 0);
        check("rst_add_b", bus.add_b, 0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Single last sample: no adder op, result the next cycle.
        ops0 = opCount;
        pushExp(32'h3F800000, 4'd0, 16'd1);
        send(32'h3F800000, 1'b1);
        check("t1_sum_valid_next_cycle", bus.sum_valid, 1);
        waitDrain();
        check("t1_no_adder_op", opCount - ops0, 0);

        // Two samples, one add.
        ops0 = opCount;
        pushExp(32'h40400000, 4'd0, 16'd2);
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        check("t2_add_start_after_hs", bus.add_start, 1);
        check("t2_busy", bus.busy, 1);
        check("t2_add_a", bus.add_a, 32'h3F800000);
        check("t2_add_b", bus.add_b, 32'h40000000);
        waitDrain();
        check("t2_one_op", opCount - ops0, 1);

        // Three samples, two adds.
        pushExp(32'h40400000, 4'd0, 16'd3);
        send(32'h3F800000, 1'b0);
        send(32'h3F000000, 1'b0);
        send(32'h3FC00000, 1'b1);
        waitDrain();

        // Zero result sets the zero flag.
        pushExp(32'h00000000, 4'b0001, 16'd2);
        send(32'h3F800000, 1'b0);
        send(32'hBF800000, 1'b1);
        waitDrain();

        // Back-pressure on the result with a new sample waiting.
        bus.sum_ready = 1'b0;
        pushExp(32'h3F800000, 4'd0, 16'd1);
        send(32'h3F800000, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40000000;
        bus.in_last  = 1'b1;
        pushExp(32'h40000000, 4'd0, 16'd1);
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_valid", bus.sum_valid, 1);
            check("t4_hold_data", bus.sum_data, 32'h3F800000);
            check("t4_hold_flags", bus.sum_flags, 0);
        end
        @(posedge clk);
        #1;
        bus.sum_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_in_ready_after_release", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("t4_new_sum_valid", bus.sum_valid, 1);
        waitDrain();

        // Adder never answers: abandon after TIMEOUT cycles.
        noDone = 1'b1;
        expRun = 32;
        pushExp(32'h40000000, 4'b1000, 16'd2);
        send(32'h40000000, 1'b0);
        send(32'h3F800000, 1'b1);
        waitDrain();
        check("t5_add_start_low", bus.add_start, 0);
        noDone = 1'b0;
        expRun = LAT + 2;

        // Reset during an add.
        skipRun = 1'b1;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        check("t6_in_add", bus.add_start, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_add_start", bus.add_start, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_sum_data", bus.sum_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        skipRun = 1'b0;
        check("t6_idle_after_rst", bus.in_ready, 1);

        // Zero-exponent sample mid-sum.
        ops0 = opCount;
        pushExp(32'h40400000, 4'd0, 16'd3);
        send(32'h40000000, 1'b0);
        send(32'h00000000, 1'b0);
        send(32'h3F800000, 1'b1);
        waitDrain();
`ifdef FP_ACCUM_SKIP_ZERO_EN
        check("t7_op_count", opCount - ops0, 1);
`else
        check("t7_op_count", opCount - ops0, 2);
`endif

        repeat (3) @(posedge clk);
        check("queue_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_accum_seq.md
# fp_accum_seq

Multi-cycle float32 accumulator sequencer. It accepts a stream of IEEE-754 single-precision samples over a valid/ready interface and drives the team's sequential FP adder unit (Start_Sig/A/B/Result/Done_Sig) as its initiator. It returns the running sum when a sample marked `last` has been absorbed. It sits between sample producers and the FP adder and owns the whole handshake with that unit.

## Interface
- `TIMEOUT`, 32: max cycles `add_start` may be held waiting for `add_done[0]` before the op is abandoned.
- `CNT_W`, 16: width of the sample counter.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: sample present.
- `in_ready` out 1: block can accept sample.
- `in_data` in 32: float32 sample.
- `in_last` in 1: sample closes the current sum.
- `sum_valid` out 1: result present.
- `sum_ready` in 1: consumer accepts result.
- `sum_data` out 32: accumulated float32.
- `sum_flags` out 4: {timeout, over, under, zero}, sticky OR over the sum.
- `sum_count` out CNT_W: samples absorbed, saturating at all-ones.
- `busy` out 1: state ≠ IDLE.
- `add_start` out 1: to adder Start_Sig (level enable).
- `add_a`, `add_b` out 32: adder operands, stable whenever `add_start`=1.
- `add_result` in 32: adder Result.
- `add_done` in 4: adder Done_Sig {over, under, zero, done}.

## Operation
- States: IDLE, WAIT_IN, ADD, DRAIN, OUT.
- IDLE: `in_ready`=1.
  - On handshake: acc←`in_data`, count←1, flags←0. The first sample never goes through the adder.
  - Next state is OUT if `in_last`, else WAIT_IN.
- WAIT_IN: `in_ready`=1.
  - On handshake: `add_a`←acc, `add_b`←`in_data`, last_r←`in_last`, count+1, timer←0.
  - Next state is ADD.
- ADD: `add_start`=1, timer increments every cycle.
  - On `add_done[0]`=1: acc←`add_result`, flags[2:0]|=`add_done[3:1]`, drain←2, next state DRAIN.
  - If timer reaches TIMEOUT−1 without done: flags[3]←1, acc unchanged, `add_start` drops next cycle, next state OUT. Any remaining samples up to `last` are then treated as a new sum.
- DRAIN: `add_start` stays 1 for exactly 2 cycles so the adder sequencer returns to its idle step. Then `add_start`=0 and next state is OUT if last_r, else WAIT_IN.
- OUT: `sum_valid`=1, with `sum_data`/`sum_flags`/`sum_count` stable. On `sum_ready`, next state is IDLE.
- `in_ready`=0 in ADD, DRAIN and OUT.
- `add_a`/`add_b` change only in WAIT_IN handshake cycles.
- `add_done[0]` seen outside ADD is ignored.
- Reset mid-operation: back to IDLE next edge and `add_start` low. The adder is not reset by this block and resynchronises through its own reset.

## Timing
- Reset values: `in_ready`=0 during reset then 1 in IDLE; `sum_valid`=0; `sum_data`=0; `sum_flags`=0; `sum_count`=0; `busy`=0; `add_start`=0; `add_a`=`add_b`=0.
- All outputs are registered except `in_ready`, `busy` and `add_start`, which are state-decoded.
- A handshake in cycle N puts the block in ADD with `add_start`=1 in cycle N+1.
- `add_done[0]` sampled in cycle D:
  - `add_start` is high through D+2 and low at D+3.
  - The block is back in WAIT_IN or OUT at D+3.
- Per-sample throughput is adder latency + 3 cycles.
- A `last` first sample: `sum_valid` rises the cycle after the handshake.
- `sum_valid` holds under back-pressure indefinitely; no sample is accepted until it is released.

## Configuration
- `FP_ACCUM_SKIP_ZERO_EN` defined: a WAIT_IN sample with exponent field 0 (±0/denormal) is counted, ADD is skipped, and last_r applies directly (OUT or stay in WAIT_IN). A first sample with exponent 0 loads acc normally.
- Undefined: every non-first sample goes through the adder.

## Test plan
1. Single sample 3F800000, `last`=1 → `sum_data`=3F800000, `sum_count`=1, `add_start` never high.
2. Samples 3F800000 then 40000000 `last` → `sum_data`=40400000, count 2; `add_start` high from handshake+1 through done+2.
3. Samples 3F800000, 3F000000, 3FC00000 `last` → 40400000, count 3; `in_ready`=0 throughout every ADD/DRAIN.
4. `sum_ready` held low 5 cycles in OUT → `sum_valid`, data and flags stable, `in_valid` samples not accepted; accepted the cycle after release.
5. Adder model never asserts done, samples 40000000, 3F800000 `last` → after 32 ADD cycles `sum_flags`=4'b1000, `sum_data`=40000000, `add_start` low.
6. With `FP_ACCUM_SKIP_ZERO_EN`, samples 40000000, 00000000, 3F800000 `last` → 40400000, count 3, exactly one adder op.
